// File: rtl/record_writer_pkg.sv
// Shared piano definitions: song-memory geometry, playback timing and the
// recorder FSM state encoding.
package record_writer_pkg;

  // Number of entries in the song memory.
  localparam int unsigned SongDepth = 26;

  // Width of a song-memory address.
  localparam int unsigned AddrW = 5;

  // Silent gap the playback block inserts between notes, in clk cycles.
  localparam int unsigned PlayGapCycles = 50_000_000;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StHold,
    StWrite,
    StTerm,
    StDone
  } rec_state_e;

endpackage

// File: rtl/record_writer.sv
// Captures held notes from the player and writes them into the song memory as
// (note, duration) entries, finishing with an end marker when stopped early.
module record_writer
  import record_writer_pkg::*;
#(
  parameter int unsigned DEPTH     = SongDepth,
  parameter int unsigned DUR_W     = 26,
  parameter int unsigned MIN_PRESS = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_button,
  input  logic             stop_button,
  input  logic             key_on_in,
  input  logic [3:0]       key_in,
  output logic             wr_en,
  output logic [AddrW-1:0] wr_addr,
  output logic [3:0]       wr_note,
  output logic [DUR_W-1:0] wr_duration,
  output logic             wr_isvalid,
  output logic             recording,
  output logic             full
);

  // One extra bit so the hold counter can saturate at 2^DUR_W.
  localparam int unsigned     CntW     = DUR_W + 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(1) << DUR_W;
  localparam logic [CntW-1:0] MinPress = CntW'(MIN_PRESS);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);

  rec_state_e       state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             full_q, full_d;
  logic [3:0]       note_q, note_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Remembers a stop seen in HOLD so the pending write is followed by TERM.
  logic             stop_pend_q, stop_pend_d;

  logic            held;
  logic            long_press;
  logic [CntW-1:0] cnt_inc;

  assign held       = key_on_in && (key_in == note_q);
  assign long_press = (cnt_q >= MinPress);
  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  // State and datapath registers; reset abandons any capture in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      full_q      <= 1'b0;
      note_q      <= 4'd0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      full_q      <= full_d;
      note_q      <= note_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state logic; start restarts the recording from any state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    full_d      = full_q;
    note_d      = note_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;

    if (start_button) begin
      state_d     = StArmed;
      addr_d      = '0;
      full_d      = 1'b0;
      stop_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StArmed: begin
          if (stop_button) begin
            state_d = StTerm;
          end else if (key_on_in && (key_in != 4'd0)) begin
            note_d  = key_in;
            cnt_d   = CntW'(1);
            state_d = StHold;
          end
        end
        StHold: begin
          if (stop_button) begin
            state_d     = long_press ? StWrite : StTerm;
            stop_pend_d = long_press;
          end else if (held) begin
            cnt_d = cnt_inc;
          end else begin
            // Release or note change; short presses are dropped.
            state_d = long_press ? StWrite : StArmed;
          end
        end
        StWrite: begin
          stop_pend_d = 1'b0;
          if (addr_q == LastAddr) begin
            full_d  = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + AddrW'(1);
            state_d = (stop_pend_q || stop_button) ? StTerm : StArmed;
          end
        end
        StTerm: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Write port and status outputs, decoded from registered state only.
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = addr_q;
    wr_note     = 4'd0;
    wr_duration = '0;
    wr_isvalid  = 1'b0;
    full        = full_q;
    recording   = (state_q == StArmed) || (state_q == StHold) ||
                  (state_q == StWrite) || (state_q == StTerm);
    if (state_q == StWrite) begin
      wr_en       = 1'b1;
      wr_note     = note_q;
      wr_isvalid  = 1'b1;
      // Playback sounds an entry for duration+1 cycles; count is at least 1.
      wr_duration = DUR_W'(cnt_q - CntW'(1));
    end else if ((state_q == StTerm) && !full_q) begin
      // End marker: all fields zero, isvalid low.
      wr_en = 1'b1;
    end
  end

endmodule

// File: tb/tb_record_writer.sv
// Scoreboard bench for record_writer: expected writes are queued as stimulus is
// driven and checked whenever the DUT strobes wr_en.
module tb_record_writer;

  localparam int unsigned DurW = 26;

  typedef struct packed {
    logic [4:0]      addr;
    logic [3:0]      note;
    logic [DurW-1:0] dur;
    logic            valid;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_button;
  logic            stop_button;
  logic            key_on_in;
  logic [3:0]      key_in;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [3:0]      wr_note;
  logic [DurW-1:0] wr_duration;
  logic            wr_isvalid;
  logic            recording;
  logic            full;

  int   n_checks = 0;
  int   n_fails  = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;

  record_writer #(
    .DEPTH    (26),
    .DUR_W    (DurW),
    .MIN_PRESS(4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_button(start_button),
    .stop_button (stop_button),
    .key_on_in   (key_on_in),
    .key_in      (key_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_note     (wr_note),
    .wr_duration (wr_duration),
    .wr_isvalid  (wr_isvalid),
    .recording   (recording),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int addr, input int note, input int dur, input bit valid);
    wr_t e;
    e.addr  = 5'(addr);
    e.note  = 4'(note);
    e.dur   = DurW'(dur);
    e.valid = valid;
    exp_q.push_back(e);
  endtask

  task automatic start_rec();
    start_button = 1'b1;
    tick(1);
    start_button = 1'b0;
    check("start_recording", 32'(recording), 32'd1);
    check("start_addr", 32'(wr_addr), 32'd0);
  endtask

  task automatic stop_rec();
    stop_button = 1'b1;
    tick(1);
    stop_button = 1'b0;
  endtask

  // Hold a note for n sampled edges, release, then let any write complete.
  task automatic press(input int note, input int n);
    key_on_in = 1'b1;
    key_in    = 4'(note);
    tick(n);
    key_on_in = 1'b0;
    key_in    = 4'd0;
    tick(3);
  endtask

  // Scoreboard monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_note", 32'(wr_note), 32'(mon_e.note));
        check("wr_duration", 32'(wr_duration), 32'(mon_e.dur));
        check("wr_isvalid", 32'(wr_isvalid), 32'(mon_e.valid));
      end
    end else begin
      check("idle_fields_zero", {1'b0, wr_isvalid, wr_note, wr_duration}, 32'd0);
    end
  end

  initial begin
    rst          = 1'b0;
    start_button = 1'b0;
    stop_button  = 1'b0;
    key_on_in    = 1'b0;
    key_in       = 4'd0;
    #3;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_recording", 32'(recording), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Inputs in IDLE are ignored.
    press(6, 6);
    stop_rec();
    tick(2);
    check("idle_recording", 32'(recording), 32'd0);

    // Single long press.
    start_rec();
    push(0, 5, 9, 1'b1);
    press(5, 10);
    check("s1_armed", 32'(recording), 32'd1);
    check("s1_addr_next", 32'(wr_addr), 32'd1);

    // Short press dropped, next press lands at address 0.
    start_rec();
    press(3, 2);
    check("s2_addr_after_short", 32'(wr_addr), 32'd0);
    push(0, 7, 5, 1'b1);
    press(7, 6);

    // Note change without release. The change edge and the write edge are
    // lost before note 4 is re-detected, so 7 edges of note 4 count 5.
    start_rec();
    push(0, 2, 7, 1'b1);
    push(1, 4, 4, 1'b1);
    key_on_in = 1'b1;
    key_in    = 4'd2;
    tick(8);
    key_in = 4'd4;
    tick(7);
    key_on_in = 1'b0;
    key_in    = 4'd0;
    tick(3);
    check("s3_addr_next", 32'(wr_addr), 32'd2);

    // Stop mid-hold with count 6: final note then end marker.
    start_rec();
    push(0, 1, 4, 1'b1);
    press(1, 5);
    push(1, 2, 4, 1'b1);
    press(2, 5);
    push(2, 6, 5, 1'b1);
    push(3, 0, 0, 1'b0);
    key_on_in = 1'b1;
    key_in    = 4'd6;
    tick(6);
    stop_button = 1'b1;
    tick(1);
    stop_button = 1'b0;
    key_on_in   = 1'b0;
    key_in      = 4'd0;
    tick(3);
    check("s4_recording_off", 32'(recording), 32'd0);
    check("s4_full", 32'(full), 32'd0);

    // Fill the memory: no end marker, later stop and keys ignored.
    start_rec();
    for (int i = 0; i < 26; i++) begin
      push(i, (i % 15) + 1, 3, 1'b1);
      press((i % 15) + 1, 4);
    end
    check("s5_full", 32'(full), 32'd1);
    check("s5_recording_off", 32'(recording), 32'd0);
    check("s5_addr_hold", 32'(wr_addr), 32'd25);
    stop_rec();
    press(9, 5);
    tick(2);
    check("s5_full_kept", 32'(full), 32'd1);
    check("s5_still_done", 32'(recording), 32'd0);

    // Asynchronous reset mid-hold discards the capture.
    start_rec();
    push(0, 8, 4, 1'b1);
    press(8, 5);
    key_on_in = 1'b1;
    key_in    = 4'd3;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    check("s6_rst_wr_en", 32'(wr_en), 32'd0);
    check("s6_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("s6_rst_recording", 32'(recording), 32'd0);
    check("s6_rst_wr_note", 32'(wr_note), 32'd0);
    tick(2);
    rst       = 1'b1;
    key_on_in = 1'b0;
    key_in    = 4'd0;
    tick(3);
    check("s6_idle_after_rst", 32'(recording), 32'd0);

    // Start wins over a simultaneous stop.
    start_button = 1'b1;
    stop_button  = 1'b1;
    tick(1);
    start_button = 1'b0;
    stop_button  = 1'b0;
    check("s6_both_recording", 32'(recording), 32'd1);
    check("s6_both_addr", 32'(wr_addr), 32'd0);
    tick(3);
    check("s6_still_armed", 32'(recording), 32'd1);
    push(0, 0, 0, 1'b0);
    stop_rec();
    tick(3);
    check("s6_stopped", 32'(recording), 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
